// File: rtl/bc_score_engine.sv
// rtl/bc_score_engine.sv - multi-cycle Bulls-and-Cows scorer with attempt tracking
// Strikes resolve in one cycle, balls one guess digit per cycle; outputs are registered.
module bc_score_engine #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int DIGIT_MAX  = 9,
  parameter int MAX_TRIES  = 10,
  localparam int CNT_W     = $clog2(NUM_DIGITS + 1),
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
  input  logic                          start,
  input  logic                          new_game,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [CNT_W-1:0]              STRIKE,
  output logic [CNT_W-1:0]              BALL,
  output logic [TRY_W-1:0]              tries,
  output logic                          win,
  output logic                          game_over
);

  localparam int                 J_W      = $clog2(NUM_DIGITS);
  localparam logic [DIGIT_W-1:0] LP_DMAX  = DIGIT_W'(DIGIT_MAX);
  localparam logic [CNT_W-1:0]   LP_NDIG  = CNT_W'(NUM_DIGITS);
  localparam logic [TRY_W-1:0]   LP_MAXT  = TRY_W'(MAX_TRIES);
  localparam logic [J_W-1:0]     LP_JLAST = J_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STRK, S_BALL, S_DONE} state_t;

  state_t                r_state;
  logic [DIGIT_W-1:0]    r_sec [NUM_DIGITS];
  logic [DIGIT_W-1:0]    r_gss [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_smask;
  logic [NUM_DIGITS-1:0] r_gmask;
  logic [CNT_W-1:0]      r_strk_acc;
  logic [CNT_W-1:0]      r_ball_acc;
  logic [J_W-1:0]        r_j;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [CNT_W-1:0]      r_strike;
  logic [CNT_W-1:0]      r_ball;
  logic [TRY_W-1:0]      r_tries;
  logic                  r_win;
  logic                  r_game_over;

  logic [DIGIT_W-1:0]    w_in_sec [NUM_DIGITS];
  logic [DIGIT_W-1:0]    w_in_gss [NUM_DIGITS];
  logic                  w_guess_ok;
  logic [CNT_W-1:0]      w_strk_cnt;
  logic [NUM_DIGITS-1:0] w_strk_mask;
  logic                  w_ball_hit;
  logic [NUM_DIGITS-1:0] w_ball_sel;
  logic [CNT_W-1:0]      w_ball_next;
  logic [TRY_W-1:0]      w_tries_next;
  logic                  w_strk_all;

  // Digit 0 sits in the most significant field of the packed inputs.
  always_comb begin
    w_guess_ok = 1'b1;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      w_in_sec[p] = secret[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W];
      w_in_gss[p] = guess[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W];
      if (w_in_gss[p] > LP_DMAX) w_guess_ok = 1'b0;
    end
  end

  always_comb begin
    w_strk_cnt  = '0;
    w_strk_mask = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (r_sec[p] == r_gss[p]) begin
        w_strk_cnt     = w_strk_cnt + CNT_W'(1);
        w_strk_mask[p] = 1'b1;
      end
    end
  end

  // Lowest unmatched secret position holding the current guess digit.
  always_comb begin
    w_ball_hit = 1'b0;
    w_ball_sel = '0;
    if (!r_gmask[r_j]) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!w_ball_hit && !r_smask[i] && (r_sec[i] == r_gss[r_j])) begin
          w_ball_hit    = 1'b1;
          w_ball_sel[i] = 1'b1;
        end
      end
    end
  end

  assign w_ball_next  = r_ball_acc + CNT_W'(w_ball_hit);
  assign w_tries_next = (r_tries == LP_MAXT) ? r_tries : r_tries + TRY_W'(1);
  assign w_strk_all   = (r_strk_acc == LP_NDIG);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sec       <= '{default: '0};
      r_gss       <= '{default: '0};
      r_smask     <= '0;
      r_gmask     <= '0;
      r_strk_acc  <= '0;
      r_ball_acc  <= '0;
      r_j         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_strike    <= '0;
      r_ball      <= '0;
      r_tries     <= '0;
      r_win       <= 1'b0;
      r_game_over <= 1'b0;
    end else if (new_game) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tries     <= '0;
      r_win       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_game_over) begin
            if (w_guess_ok) begin
              r_sec   <= w_in_sec;
              r_gss   <= w_in_gss;
              r_busy  <= 1'b1;
              r_state <= S_STRK;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_STRK: begin
          r_strk_acc <= w_strk_cnt;
          r_smask    <= w_strk_mask;
          r_gmask    <= w_strk_mask;
          r_ball_acc <= '0;
          r_j        <= '0;
          r_state    <= S_BALL;
        end
        S_BALL: begin
          r_ball_acc <= w_ball_next;
          r_smask    <= r_smask | w_ball_sel;
          if (w_ball_hit) r_gmask[r_j] <= 1'b1;
          r_j <= r_j + J_W'(1);
          // Results are published on entry to DONE so they coincide with the done pulse.
          if (r_j == LP_JLAST) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_strike    <= r_strk_acc;
            r_ball      <= w_ball_next;
            r_tries     <= w_tries_next;
            r_win       <= r_win | w_strk_all;
            r_game_over <= r_game_over | r_win | w_strk_all | (w_tries_next == LP_MAXT);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign STRIKE    = r_strike;
  assign BALL      = r_ball;
  assign tries     = r_tries;
  assign win       = r_win;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_bc_score_engine.sv
// tb/tb_bc_score_engine.sv - directed scoreboard bench for bc_score_engine
module tb_bc_score_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, start0, ng0;
  logic [15:0] sec0, gs0;
  logic        busy0, done0, err0, win0, go0;
  logic [2:0]  st0, bl0;
  logic [3:0]  tr0;

  logic        rst1, start1, ng1;
  logic [23:0] sec1, gs1;
  logic        busy1, done1, err1, win1, go1;
  logic [2:0]  st1, bl1;
  logic [1:0]  tr1;

  bc_score_engine u0 (
    .clk(clk), .rst(rst0), .secret(sec0), .guess(gs0), .start(start0), .new_game(ng0),
    .busy(busy0), .done(done0), .err(err0), .STRIKE(st0), .BALL(bl0), .tries(tr0),
    .win(win0), .game_over(go0)
  );

  bc_score_engine #(.NUM_DIGITS(6), .MAX_TRIES(3)) u1 (
    .clk(clk), .rst(rst1), .secret(sec1), .guess(gs1), .start(start1), .new_game(ng1),
    .busy(busy1), .done(done1), .err(err1), .STRIKE(st1), .BALL(bl1), .tries(tr1),
    .win(win1), .game_over(go1)
  );

  logic [31:0] o_busy [2], o_done [2], o_err [2], o_st [2], o_bl [2], o_tr [2], o_win [2], o_go [2];
  assign o_busy[0] = 32'(busy0);  assign o_busy[1] = 32'(busy1);
  assign o_done[0] = 32'(done0);  assign o_done[1] = 32'(done1);
  assign o_err[0]  = 32'(err0);   assign o_err[1]  = 32'(err1);
  assign o_st[0]   = 32'(st0);    assign o_st[1]   = 32'(st1);
  assign o_bl[0]   = 32'(bl0);    assign o_bl[1]   = 32'(bl1);
  assign o_tr[0]   = 32'(tr0);    assign o_tr[1]   = 32'(tr1);
  assign o_win[0]  = 32'(win0);   assign o_win[1]  = 32'(win1);
  assign o_go[0]   = 32'(go0);    assign o_go[1]   = 32'(go1);

  typedef struct {int s; int b; int t; int w; int g;} exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   e_tries [2] = '{0, 0};
  int   e_win   [2] = '{0, 0};
  int   e_go    [2] = '{0, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference scoring by digit-count histograms of the non-strike positions.
  function automatic void score(input logic [23:0] s, input logic [23:0] g, input int n,
                                output int st, output int bl);
    int cs [16];
    int cg [16];
    logic [3:0] ds, dg;
    st = 0;
    bl = 0;
    for (int v = 0; v < 16; v++) begin cs[v] = 0; cg[v] = 0; end
    for (int p = 0; p < n; p++) begin
      ds = s[(n-1-p)*4 +: 4];
      dg = g[(n-1-p)*4 +: 4];
      if (ds == dg) st++;
      else begin cs[ds]++; cg[dg]++; end
    end
    for (int v = 0; v < 16; v++) bl += (cs[v] < cg[v]) ? cs[v] : cg[v];
  endfunction

  task automatic set_start(input int k, input logic v);
    if (k == 0) start0 = v; else start1 = v;
  endtask

  task automatic pulse_new_game(input int k);
    if (k == 0) ng0 = 1'b1; else ng1 = 1'b1;
    tick();
    if (k == 0) ng0 = 1'b0; else ng1 = 1'b0;
    e_tries[k] = 0;
    e_win[k]   = 0;
    e_go[k]    = 0;
  endtask

  task automatic eval(input int k, input logic [23:0] s, input logic [23:0] g);
    int st, bl, lat, n, mt;
    exp_t e;
    n  = (k == 0) ? 4 : 6;
    mt = (k == 0) ? 10 : 3;
    score(s, g, n, st, bl);
    e_tries[k] = (e_tries[k] < mt) ? e_tries[k] + 1 : mt;
    if (st == n) e_win[k] = 1;
    e_go[k] = (e_win[k] != 0 || e_tries[k] == mt) ? 1 : 0;
    sb.push_back('{st, bl, e_tries[k], e_win[k], e_go[k]});
    if (k == 0) begin sec0 = s[15:0]; gs0 = g[15:0]; end
    else begin sec1 = s; gs1 = g; end
    set_start(k, 1'b1);
    tick();
    set_start(k, 1'b0);
    // Disturb the inputs mid-flight; the latched copy must be used.
    if (k == 0) begin sec0 = 16'($urandom); gs0 = 16'($urandom); end
    else begin sec1 = 24'($urandom); gs1 = 24'($urandom); end
    chk("busy_c1", o_busy[k], 1);
    lat = 1;
    while (o_done[k] !== 32'd1 && lat < 30) begin
      tick();
      lat++;
    end
    chk("done_latency", 32'(lat), 32'(n + 2));
    e = sb.pop_front();
    chk("strike", o_st[k], 32'(e.s));
    chk("ball", o_bl[k], 32'(e.b));
    chk("tries", o_tr[k], 32'(e.t));
    chk("win", o_win[k], 32'(e.w));
    chk("game_over", o_go[k], 32'(e.g));
    tick();
    chk("done_one_cycle", o_done[k], 0);
    chk("busy_after", o_busy[k], 0);
  endtask

  task automatic chk_reset(input int k);
    chk("rst_busy", o_busy[k], 0);
    chk("rst_done", o_done[k], 0);
    chk("rst_err", o_err[k], 0);
    chk("rst_strike", o_st[k], 0);
    chk("rst_ball", o_bl[k], 0);
    chk("rst_tries", o_tr[k], 0);
    chk("rst_win", o_win[k], 0);
    chk("rst_go", o_go[k], 0);
  endtask

  initial begin
    int dcnt;
    rst0 = 1'b1; start0 = 1'b0; ng0 = 1'b0; sec0 = '0; gs0 = '0;
    rst1 = 1'b1; start1 = 1'b0; ng1 = 1'b0; sec1 = '0; gs1 = '0;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    chk_reset(0);
    chk_reset(1);

    // Winning guess, then start is ignored once the game is over.
    eval(0, 24'h1234, 24'h1234);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    chk("ignored_busy", o_busy[0], 0);
    chk("ignored_err", o_err[0], 0);
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (done0) dcnt++; end
    chk("ignored_no_done", 32'(dcnt), 0);

    pulse_new_game(0);
    chk("ng_tries", o_tr[0], 0);
    chk("ng_go", o_go[0], 0);
    chk("ng_win", o_win[0], 0);
    chk("ng_strike_kept", o_st[0], 4);

    eval(0, 24'h1234, 24'h4321);
    eval(0, 24'h1123, 24'h1312);
    eval(0, 24'h1111, 24'h1222);
    eval(0, 24'h1122, 24'h2211);

    // Out-of-range guess digit.
    sec0 = 16'h1234; gs0 = 16'h12A4;
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    chk("err_c1", o_err[0], 1);
    chk("err_busy", o_busy[0], 0);
    chk("err_tries", o_tr[0], 32'(e_tries[0]));
    tick();
    chk("err_one_cycle", o_err[0], 0);

    // Abort with new_game during cycle 3 of an evaluation.
    sec0 = 16'h5678; gs0 = 16'h1234;
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    tick(); tick();
    pulse_new_game(0);
    chk("abort_busy", o_busy[0], 0);
    chk("abort_tries", o_tr[0], 0);
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (done0) dcnt++; end
    chk("abort_no_done", 32'(dcnt), 0);
    chk("abort_strike_kept", o_st[0], 0);
    chk("abort_ball_kept", o_bl[0], 4);

    // Six-digit instance with three tries per game.
    eval(1, 24'h123456, 24'h654321);
    eval(1, 24'h111111, 24'h222222);
    eval(1, 24'h123456, 24'h124356);
    pulse_new_game(1);
    chk("ng1_tries", o_tr[1], 0);
    chk("ng1_go", o_go[1], 0);
    chk("ng1_strike_kept", o_st[1], 4);
    chk("ng1_ball_kept", o_bl[1], 2);

    // Reset in cycle 4 of an evaluation.
    sec1 = 24'h123456; gs1 = 24'h654321;
    set_start(1, 1'b1);
    tick();
    set_start(1, 1'b0);
    tick(); tick(); tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk_reset(1);
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (done1) dcnt++; end
    chk("rst_no_done", 32'(dcnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
